// File: rtl/updown_seq_decoder.sv
// Recovers up/down direction, run length and illegal-jump errors from a 2-bit counter's states.
// Optional: define UPDOWN_SAMPLE_EDGE_EN to treat sample as a raw level (synchronised, edge-detected).
module updown_seq_decoder #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             cp,
   input  logic             rst,
   input  logic             sample,
   input  logic             clr,
   input  logic [1:0]       y_in,
   output logic             dir_out,
   output logic             valid,
   output logic             err,
   output logic [CNT_W-1:0] step_cnt,
   output logic [1:0]       prev_out
);

   typedef enum logic [1:0] {StIdle, StTrack, StError} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   state_e           state_q, state_d;
   logic             dir_d, valid_d, err_d;
   logic [CNT_W-1:0] cnt_d;
   logic [1:0]       prev_d;
   logic [1:0]       delta;
   logic             strobe;

`ifdef UPDOWN_SAMPLE_EDGE_EN
   logic sync1_q, sync2_q, sync3_q;

   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= sample;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign strobe = sync2_q & ~sync3_q;
`else
   assign strobe = sample;
`endif

   // Modulo-4 wrap makes 11->00 an up step and 00->11 a down step.
   assign delta = y_in - prev_out;

   always_comb begin
      state_d = state_q;
      dir_d   = dir_out;
      valid_d = valid;
      err_d   = err;
      cnt_d   = step_cnt;
      prev_d  = prev_out;
      if (clr) begin
         state_d = StIdle;
         dir_d   = 1'b0;
         valid_d = 1'b0;
         err_d   = 1'b0;
         cnt_d   = '0;
         prev_d  = 2'b00;
      end else if (strobe) begin
         case (state_q)
            StIdle: begin
               prev_d  = y_in;
               state_d = StTrack;
            end
            StTrack: begin
               unique case (delta)
                  2'd1, 2'd3: begin
                     prev_d  = y_in;
                     valid_d = 1'b1;
                     if (valid && (dir_out == delta[1])) begin
                        cnt_d = (step_cnt == CntMax) ? step_cnt : step_cnt + CntOne;
                     end else begin
                        dir_d = delta[1];
                        cnt_d = CntOne;
                     end
                  end
                  2'd2: begin
                     err_d   = 1'b1;
                     valid_d = 1'b0;
                     cnt_d   = '0;
                     state_d = StError;
                  end
                  default: ;
               endcase
            end
            StError: ;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         dir_out  <= 1'b0;
         valid    <= 1'b0;
         err      <= 1'b0;
         step_cnt <= '0;
         prev_out <= 2'b00;
      end else begin
         state_q  <= state_d;
         dir_out  <= dir_d;
         valid    <= valid_d;
         err      <= err_d;
         step_cnt <= cnt_d;
         prev_out <= prev_d;
      end
   end

endmodule
